// File: rtl/if_pkg.sv
// Shared constants, fetch FSM encoding and the buffered fetch entry for the fetch stage.
package if_pkg;

   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } fetch_state_e;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } fetch_entry_t;

   localparam int ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/if_fifo.sv
// Small synchronous FIFO; head is visible combinationally, push/pop land on the next edge.
// Flush empties it and beats a same-cycle push; pushes into a full FIFO are dropped.
module if_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 64,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = AW + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_dat,
   input  logic             pop,
   input  logic             flush,
   output logic [WIDTH-1:0] head_dat,
   output logic [CW-1:0]    count,
   output logic             full,
   output logic             empty
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    wr_ptr;
   logic             do_push;
   logic             do_pop;

   assign full     = (count == CW'(DEPTH));
   assign empty    = (count == '0);
   assign do_push  = push & ~full & ~flush;
   assign do_pop   = pop & ~empty & ~flush;
   assign head_dat = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_dat;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch: owns the PC, keeps <= FIFO_DEPTH words buffered or in flight, hands {pc, instr} to decode.
// Response to id_valid is one cycle after rvalid; redirects flush and drain stale responses. Optional IF_PERF_CNT_EN adds perf counters.
module if_fetch_stage
   import if_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   output logic             inst_req,
   output logic [XLEN-1:0]  inst_addr,
   input  logic             inst_gnt,
   input  logic             inst_rvalid,
   input  logic [XLEN-1:0]  inst_rdata,
   output logic             id_valid,
   input  logic             id_ready,
   output logic [XLEN-1:0]  id_pc,
   output logic [XLEN-1:0]  id_instr,
   input  logic             redirect_valid,
   input  logic [XLEN-1:0]  redirect_pc
`ifdef IF_PERF_CNT_EN
   ,
   output logic [31:0]      perf_stall_cnt,
   output logic [31:0]      perf_flush_cnt
`endif
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   fetch_state_e    state;
   fetch_state_e    state_nxt;
   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] pc_nxt;
   logic [XLEN-1:0] resp_pc;
   logic [XLEN-1:0] resp_pc_nxt;
   logic [XLEN-1:0] target;
   logic [CW-1:0]   outstanding;
   logic [CW-1:0]   out_nxt;
   logic [CW-1:0]   drop_cnt;
   logic [CW-1:0]   drop_nxt;
   logic [CW-1:0]   fifo_count;
   logic [CW:0]     credit_used;
   logic            credit_ok;
   logic            fifo_push;
   logic            fifo_pop;
   logic            fifo_flush;
   logic            fifo_full;
   logic            fifo_empty;
   fetch_entry_t    push_entry;
   fetch_entry_t    head_entry;

   assign target     = redirect_pc & ~32'h3;
   assign inst_addr  = pc;
   assign push_entry = '{pc: resp_pc, instr: inst_rdata};

   assign id_valid = ~fifo_empty;
   assign fifo_pop = id_valid & id_ready;
   assign id_pc    = id_valid ? head_entry.pc : '0;
   assign id_instr = id_valid ? head_entry.instr : '0;

   // The slot freed by this cycle's pop counts as credit, so a steady stream runs at one word per cycle.
   assign credit_used = {1'b0, fifo_count} + {1'b0, outstanding} - {{CW{1'b0}}, fifo_pop};
   assign credit_ok   = credit_used < (CW+1)'(FIFO_DEPTH);

   always_comb begin
      state_nxt   = state;
      inst_req    = 1'b0;
      fifo_push   = 1'b0;
      fifo_flush  = 1'b0;
      pc_nxt      = pc;
      resp_pc_nxt = resp_pc;
      out_nxt     = outstanding;
      drop_nxt    = drop_cnt;
      unique case (state)
         BOOT: begin
            state_nxt = RUN;
         end
         RUN: begin
            inst_req = credit_ok & ~redirect_valid;
            if (inst_req && inst_gnt) begin
               pc_nxt  = pc + 32'd4;
               out_nxt = out_nxt + CW'(1);
            end
            if (inst_rvalid) begin
               fifo_push   = 1'b1;
               resp_pc_nxt = resp_pc + 32'd4;
               out_nxt     = out_nxt - CW'(1);
            end
         end
         DRAIN: begin
            if (inst_rvalid) begin
               drop_nxt = drop_cnt - CW'(1);
            end
            if (drop_nxt == '0) begin
               state_nxt = RUN;
            end
         end
         default: begin
            state_nxt = BOOT;
         end
      endcase
      // Everything still in flight, minus a response landing now, becomes stale.
      if (redirect_valid && state != BOOT) begin
         fifo_flush  = 1'b1;
         fifo_push   = 1'b0;
         pc_nxt      = target;
         resp_pc_nxt = target;
         drop_nxt    = drop_cnt + outstanding + CW'(inst_req & inst_gnt) - CW'(inst_rvalid);
         out_nxt     = '0;
         state_nxt   = (drop_nxt == '0) ? RUN : DRAIN;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= BOOT;
         pc          <= RESET_PC;
         resp_pc     <= RESET_PC;
         outstanding <= '0;
         drop_cnt    <= '0;
      end else begin
         state       <= state_nxt;
         pc          <= pc_nxt;
         resp_pc     <= resp_pc_nxt;
         outstanding <= out_nxt;
         drop_cnt    <= drop_nxt;
      end
   end

   if_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (ENTRY_W)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (fifo_push),
      .push_dat (push_entry),
      .pop      (fifo_pop),
      .flush    (fifo_flush),
      .head_dat (head_entry),
      .count    (fifo_count),
      .full     (fifo_full),
      .empty    (fifo_empty)
   );

   a_no_rvalid_when_full : assert property (@(posedge clk) disable iff (rst)
      !(state == RUN && inst_rvalid && fifo_full));

`ifdef IF_PERF_CNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_stall_cnt <= '0;
         perf_flush_cnt <= '0;
      end else begin
         if (id_valid && !id_ready && perf_stall_cnt != 32'hFFFF_FFFF) begin
            perf_stall_cnt <= perf_stall_cnt + 32'd1;
         end
         if (redirect_valid && perf_flush_cnt != 32'hFFFF_FFFF) begin
            perf_flush_cnt <= perf_flush_cnt + 32'd1;
         end
      end
   end
`endif

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
Instruction-fetch stage feeding the instruction decoder (main/ALU decode) in the single-issue MIPS pipeline.
- Owns the PC.
- Issues in-order requests to instruction memory.
- Buffers returned words with their PC in a small FIFO.
- Presents one {pc, instr} at a time to decode over a valid/ready handshake.
- Honours branch/jump redirects from decode by flushing buffered and in-flight fetches.

Parameters:
RESET_PC, 32'h0000_0000, PC value fetched first after reset.
FIFO_DEPTH, 2, entries in the fetch buffer; also the maximum number of outstanding memory requests (power of two, ≥2).

Ports:
clk  in  1  clock; all state changes on rising edge.
rst  in  1  asynchronous, active-high reset.
inst_req  out  1  request valid to instruction memory.
inst_addr  out  32  word-aligned fetch address (current PC).
inst_gnt  in  1  memory accepted the request this cycle (inst_req & inst_gnt = issued).
inst_rvalid  in  1  read data valid; responses return in issue order, ≥1 cycle after grant.
inst_rdata  in  32  instruction word.
id_valid  out  1  {id_pc, id_instr} valid to decode.
id_ready  in  1  decode consumes the head entry this cycle.
id_pc  out  32  PC of the presented instruction.
id_instr  out  32  presented instruction word.
redirect_valid  in  1  branch taken / jump from decode.
redirect_pc  in  32  new fetch target; bits [1:0] ignored (forced 0).

Behaviour:
Reset values:
- inst_req=0, inst_addr=RESET_PC, id_valid=0, id_pc=0, id_instr=0.
- FIFO empty, outstanding=0, drop_cnt=0, state=BOOT.

FSM:
- BOOT: one cycle with no request, then RUN.
- RUN: normal fetching.
- DRAIN: in-flight responses from a redirected stream are being discarded; no new requests. Leave to RUN when drop_cnt reaches 0 (the cycle after the last stale rvalid). If drop_cnt is 0 at redirect, go straight to RUN.

Issue rule:
- inst_req=1 only in RUN, when fifo_count + outstanding < FIFO_DEPTH, and no redirect this cycle.
- On grant: PC ← PC+4 (32-bit wrap, 0xFFFF_FFFC → 0), outstanding++.

Response handling:
- In RUN, rvalid pushes {pc_of_response, inst_rdata} into the FIFO and decrements outstanding.
- Response PC is tracked via a second counter-based PC (resp_pc += 4 per accepted response).
- Space is guaranteed by the credit rule; rvalid while the FIFO is full is an assertion error.

Decode side:
- id_valid = FIFO non-empty; outputs show the head entry combinationally from the FIFO registers.
- Pop on id_valid & id_ready.
- Latency: grant at cycle N, rvalid at N+k → id_valid at N+k+1.

Redirect (any state except BOOT):
- FIFO flushed.
- PC ← redirect_pc; resp_pc ← redirect_pc.
- drop_cnt ← outstanding + (grant this cycle ? 1 : 0) − (rvalid this cycle ? 1 : 0); outstanding ← 0.
- A grant in the same cycle cannot occur, because req is deasserted on redirect.
- Redirect with a simultaneous pop: the pop counts, and the flush wins for all other entries.
- Redirect during DRAIN: drop_cnt keeps counting and the new target replaces PC.

Discarding in DRAIN:
- rvalid decrements drop_cnt; data is discarded.

Reset:
- Reset mid-operation discards everything immediately.
- Memory must also be reset on rst; late responses after reset are a protocol error.

Optional Feature:
Macro IF_PERF_CNT_EN.
- Defined: adds outputs perf_stall_cnt [31:0] and perf_flush_cnt [31:0], both reset to 0, saturating at 32'hFFFF_FFFF.
  - perf_stall_cnt increments each cycle with id_valid=1 & id_ready=0.
  - perf_flush_cnt increments on each redirect_valid.
- Undefined: ports and logic are absent; functional behaviour is otherwise identical.

Decomposition:
Shared package if_pkg holds:
- RESET_PC default.
- Word/address width constants (32).
- Fetch-state encoding BOOT/RUN/DRAIN.
- The fetch_entry struct {pc[31:0], instr[31:0]}.

Sub-module if_fifo:
- Synchronous FIFO, parameters DEPTH and WIDTH=64.
- Ports: push, pop, flush, count, full, empty.
- Async active-high reset.
- Flush has priority over push in the same cycle.

Test Plan:
1. Reset then memory with grant always 1 and 1-cycle rvalid, id_ready=1 → inst_addr sequence 0,4,8,…; first id_valid 3 cycles after rst falls with id_pc=0; one instruction per cycle thereafter.
2. id_ready=0 for 10 cycles → at most FIFO_DEPTH entries buffered, inst_req drops to 0, no lost or duplicated PCs when ready returns.
3. Redirect to 32'h0000_0100 with 2 requests outstanding (3-cycle memory latency) → next 2 rvalids discarded, FSM in DRAIN, first delivered id_pc=0x100, then 0x104.
4. Redirect_pc=32'h0000_0103 → fetch address 0x100.
5. Redirect coincident with id_valid & id_ready and an rvalid → drop_cnt correct, no stale instruction delivered; PC 32'hFFFF_FFFC fetch → next inst_addr 0.
6. Assert rst during DRAIN with the FIFO full → all outputs at reset values the same cycle; fetch restarts at RESET_PC after BOOT. With IF_PERF_CNT_EN, scenario 2 gives perf_stall_cnt=10 and scenario 3 gives perf_flush_cnt=1.
